// File: rtl/load_store_unit.sv
// load_store_unit: data-memory side of the LSU.
// Accepts one load/store from decode, runs the dmem request/grant/response
// handshake, formats byte/halfword lanes and returns extended load data.
// Only one access is outstanding at a time.
//
// Operator encoding (lsu_operator_ip, load_store_func_code):
//   0 LW, 1 LH, 2 LB, 3 LHU, 4 LBU, 5 SW, 6 SH, 7 SB
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword
// and word accesses (adds the misalign_err_op port). Without it, low address
// bits beyond the access size are ignored and the access proceeds normally.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en_lsu_ip,
    input  logic [2:0]            lsu_operator_ip,
    input  logic [ADDR_WIDTH-1:0] addr_ip,
    input  logic [DATA_WIDTH-1:0] wdata_ip,
    output logic [DATA_WIDTH-1:0] mem_data_op,
    output logic                  mem_data_valid_op,
    output logic                  done_op,
    output logic                  busy_op,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic                  misalign_err_op,
`endif
    output logic                  dmem_req_op,
    output logic                  dmem_we_op,
    output logic [3:0]            dmem_be_op,
    output logic [ADDR_WIDTH-1:0] dmem_addr_op,
    output logic [DATA_WIDTH-1:0] dmem_wdata_op,
    input  logic                  dmem_gnt_ip,
    input  logic                  dmem_rvalid_ip,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_ip
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] op_q;       // operator latched at acceptance
    logic [1:0] addr_lo_q;  // byte offset latched at acceptance
    logic       trap;       // current request is trapped as misaligned

    function automatic logic is_load(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LB) ||
               (op == OP_LHU) || (op == OP_LBU);
    endfunction

    function automatic logic is_byte(input logic [2:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    endfunction

    function automatic logic is_half(input logic [2:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] op, input logic [1:0] a);
        if (is_byte(op))
            return 4'b0001 << a;
        else if (is_half(op))
            return 4'b0011 << {a[1], 1'b0};
        else
            return 4'b1111;
    endfunction

    // Store data is replicated across lanes so the byte enables pick the right copy.
    function automatic logic [DATA_WIDTH-1:0] store_data(input logic [2:0] op,
                                                         input logic [DATA_WIDTH-1:0] w);
        if (is_byte(op))
            return {4{w[7:0]}};
        else if (is_half(op))
            return {2{w[15:0]}};
        else
            return w;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [2:0] op,
                                                           input logic [1:0] a,
                                                           input logic [DATA_WIDTH-1:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [DATA_WIDTH-1:0] res;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_LB:   res = {{24{b[7]}}, b};
            OP_LBU:  res = {24'd0, b};
            OP_LH:   res = {{16{h[15]}}, h};
            OP_LHU:  res = {16'd0, h};
            default: res = rd;
        endcase
        return res;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        if (is_half(op))
            return a[0];
        else if (!is_byte(op))
            return a != 2'd0;
        else
            return 1'b0;
    endfunction
`endif

    // Decide whether the request being sampled is trapped instead of issued.
    always_comb begin
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = misaligned(lsu_operator_ip, addr_ip[1:0]);
`else
        trap = 1'b0;
`endif
    end

    // Access FSM with all outputs registered; reset abandons any access in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            op_q              <= OP_LW;
            addr_lo_q         <= 2'd0;
            mem_data_op       <= '0;
            mem_data_valid_op <= 1'b0;
            done_op           <= 1'b0;
            busy_op           <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_err_op   <= 1'b0;
`endif
            dmem_req_op       <= 1'b0;
            dmem_we_op        <= 1'b0;
            dmem_be_op        <= 4'b0000;
            dmem_addr_op      <= '0;
            dmem_wdata_op     <= '0;
        end else begin
            done_op           <= 1'b0;
            mem_data_valid_op <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_err_op   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (en_lsu_ip) begin
                        op_q      <= lsu_operator_ip;
                        addr_lo_q <= addr_ip[1:0];
                        busy_op   <= 1'b1;
                        if (trap) begin
                            state           <= DONE;
                            done_op         <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                            misalign_err_op <= 1'b1;
`endif
                        end else begin
                            state         <= REQ;
                            dmem_req_op   <= 1'b1;
                            dmem_we_op    <= !is_load(lsu_operator_ip);
                            dmem_be_op    <= byte_enable(lsu_operator_ip, addr_ip[1:0]);
                            dmem_addr_op  <= {addr_ip[ADDR_WIDTH-1:2], 2'b00};
                            dmem_wdata_op <= store_data(lsu_operator_ip, wdata_ip);
                        end
                    end
                end
                REQ: begin
                    // A response arriving alongside the grant is not ours; only the grant counts.
                    if (dmem_gnt_ip) begin
                        state       <= WAIT;
                        dmem_req_op <= 1'b0;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_ip) begin
                        state   <= DONE;
                        done_op <= 1'b1;
                        if (is_load(op_q)) begin
                            mem_data_valid_op <= 1'b1;
                            mem_data_op       <= load_extract(op_q, addr_lo_q, dmem_rdata_ip);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy_op <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard testbench for load_store_unit: directed accesses push expected
// memory requests and completions; a negedge monitor pops and compares them.
module tb_load_store_unit;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    logic        clock = 1'b0;
    logic        reset;
    logic        en_lsu_ip;
    logic [2:0]  lsu_operator_ip;
    logic [31:0] addr_ip;
    logic [31:0] wdata_ip;
    logic [31:0] mem_data_op;
    logic        mem_data_valid_op;
    logic        done_op;
    logic        busy_op;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_err_op;
`endif
    logic        dmem_req_op;
    logic        dmem_we_op;
    logic [3:0]  dmem_be_op;
    logic [31:0] dmem_addr_op;
    logic [31:0] dmem_wdata_op;
    logic        dmem_gnt_ip;
    logic        dmem_rvalid_ip;
    logic [31:0] dmem_rdata_ip;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          chk_wd;
    } req_t;

    typedef struct {
        logic        is_load;
        logic [31:0] data;
        logic        err;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];
    int    checks   = 0;
    int    failures = 0;
    logic [31:0] last_data = 32'h0;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock             (clock),
        .reset             (reset),
        .en_lsu_ip         (en_lsu_ip),
        .lsu_operator_ip   (lsu_operator_ip),
        .addr_ip           (addr_ip),
        .wdata_ip          (wdata_ip),
        .mem_data_op       (mem_data_op),
        .mem_data_valid_op (mem_data_valid_op),
        .done_op           (done_op),
        .busy_op           (busy_op),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign_err_op   (misalign_err_op),
`endif
        .dmem_req_op       (dmem_req_op),
        .dmem_we_op        (dmem_we_op),
        .dmem_be_op        (dmem_be_op),
        .dmem_addr_op      (dmem_addr_op),
        .dmem_wdata_op     (dmem_wdata_op),
        .dmem_gnt_ip       (dmem_gnt_ip),
        .dmem_rvalid_ip    (dmem_rvalid_ip),
        .dmem_rdata_ip     (dmem_rdata_ip)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: compares live requests and completions against the scoreboard.
    always @(negedge clock) begin
        if (reset !== 1'b1) begin
            if (dmem_req_op) begin
                if (req_q.size() == 0) begin
                    chk("req_unexpected", 32'(dmem_req_op), 32'd0);
                end else begin
                    chk("req_addr", dmem_addr_op, req_q[0].addr);
                    chk("req_we", 32'(dmem_we_op), 32'(req_q[0].we));
                    chk("req_be", 32'(dmem_be_op), 32'(req_q[0].be));
                    if (req_q[0].chk_wd)
                        chk("req_wdata", dmem_wdata_op, req_q[0].wd);
                    if (dmem_gnt_ip)
                        void'(req_q.pop_front());
                end
            end
            if (mem_data_valid_op && !done_op)
                chk("valid_without_done", 32'(done_op), 32'd1);
            if (done_op) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 32'(done_op), 32'd0);
                end else begin
                    done_t e;
                    e = done_q.pop_front();
                    chk("rsp_valid", 32'(mem_data_valid_op), 32'(e.is_load));
                    chk("rsp_data", mem_data_op, e.data);
`ifdef LSU_MISALIGN_TRAP_EN
                    chk("rsp_misalign", 32'(misalign_err_op), 32'(e.err));
`endif
                end
            end
        end
    end

    // Issue one access and play the memory side with the given grant/response delays.
    task automatic access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int gnt_dly, input int rv_dly,
                          input bit noise, input bit extra_en, input bit exp_trap,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_data);
        logic  ld;
        req_t  r;
        done_t d;
        ld = (op <= OP_LBU);
        d.is_load = ld && !exp_trap;
        d.data    = (ld && !exp_trap) ? exp_data : last_data;
        d.err     = exp_trap;
        if (ld && !exp_trap) last_data = exp_data;
        done_q.push_back(d);
        if (!exp_trap) begin
            r.addr = {addr[31:2], 2'b00};
            r.we = !ld;
            r.be = exp_be;
            r.wd = exp_wd;
            r.chk_wd = !ld;
            req_q.push_back(r);
        end
        en_lsu_ip = 1'b1;
        lsu_operator_ip = op;
        addr_ip = addr;
        wdata_ip = wd;
        @(posedge clock); #1;
        en_lsu_ip = 1'b0;
        wdata_ip = 32'h0;
        chk("busy_rise", 32'(busy_op), 32'd1);
        if (exp_trap) begin
            chk("trap_no_req", 32'(dmem_req_op), 32'd0);
            chk("trap_done_cycle1", 32'(done_op), 32'd1);
        end else begin
            chk("req_cycle1", 32'(dmem_req_op), 32'd1);
            for (int i = 0; i < gnt_dly; i++) begin
                dmem_rvalid_ip = noise;
                if (extra_en && i == 0) begin
                    en_lsu_ip = 1'b1;
                    lsu_operator_ip = OP_LW;
                    addr_ip = 32'h600;
                    wdata_ip = 32'hFFFFFFFF;
                end else begin
                    en_lsu_ip = 1'b0;
                end
                @(posedge clock); #1;
                en_lsu_ip = 1'b0;
                chk("req_held", 32'(dmem_req_op), 32'd1);
            end
            dmem_gnt_ip = 1'b1;
            dmem_rvalid_ip = noise;
            @(posedge clock); #1;
            dmem_gnt_ip = 1'b0;
            dmem_rvalid_ip = 1'b0;
            chk("req_drop_wait", 32'(dmem_req_op), 32'd0);
            chk("no_done_in_wait", 32'(done_op), 32'd0);
            for (int j = 0; j < rv_dly; j++) begin
                @(posedge clock); #1;
                chk("wait_no_done", 32'(done_op), 32'd0);
            end
            dmem_rvalid_ip = 1'b1;
            dmem_rdata_ip = rd;
            @(posedge clock); #1;
            dmem_rvalid_ip = 1'b0;
            dmem_rdata_ip = 32'h0;
            chk("done_latency", 32'(done_op), 32'd1);
            chk("busy_in_done", 32'(busy_op), 32'd1);
        end
        @(posedge clock); #1;
        chk("busy_fall", 32'(busy_op), 32'd0);
        chk("done_one_cycle", 32'(done_op), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(dmem_req_op), 32'd0);
        chk({tag, "_we"}, 32'(dmem_we_op), 32'd0);
        chk({tag, "_be"}, 32'(dmem_be_op), 32'd0);
        chk({tag, "_addr"}, dmem_addr_op, 32'd0);
        chk({tag, "_wdata"}, dmem_wdata_op, 32'd0);
        chk({tag, "_data"}, mem_data_op, 32'd0);
        chk({tag, "_valid"}, 32'(mem_data_valid_op), 32'd0);
        chk({tag, "_done"}, 32'(done_op), 32'd0);
        chk({tag, "_busy"}, 32'(busy_op), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk({tag, "_misalign"}, 32'(misalign_err_op), 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b1;
        en_lsu_ip = 1'b0;
        lsu_operator_ip = OP_LW;
        addr_ip = 32'h0;
        wdata_ip = 32'h0;
        dmem_gnt_ip = 1'b0;
        dmem_rvalid_ip = 1'b0;
        dmem_rdata_ip = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        // op, addr, wdata, rdata, gnt_dly, rv_dly, noise, extra_en, trap, be, wdata_exp, data_exp
        access(OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 0, 4'hF,    32'h0,        32'hDEADBEEF);
        access(OP_LB,  32'h103, 32'h0,        32'h80123456, 0, 0, 0, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80);
        access(OP_LBU, 32'h103, 32'h0,        32'h80123456, 0, 1, 0, 0, 0, 4'b1000, 32'h0,        32'h00000080);
        access(OP_LHU, 32'h102, 32'h0,        32'h80011234, 1, 0, 0, 0, 0, 4'b1100, 32'h0,        32'h00008001);
        access(OP_LH,  32'h100, 32'h0,        32'h1234F00F, 0, 0, 0, 0, 0, 4'b0011, 32'h0,        32'hFFFFF00F);
        access(OP_LB,  32'h001, 32'h0,        32'h00007F00, 0, 0, 0, 0, 0, 4'b0010, 32'h0,        32'h0000007F);
        access(OP_SB,  32'h201, 32'h12345678, 32'h0,        0, 0, 0, 0, 0, 4'b0010, 32'h78787878, 32'h0);
        access(OP_SH,  32'h302, 32'h12345678, 32'h0,        3, 0, 1, 1, 0, 4'b1100, 32'h56785678, 32'h0);
        access(OP_SW,  32'h404, 32'hA5A50F0F, 32'h0,        0, 2, 1, 0, 0, 4'hF,    32'hA5A50F0F, 32'h0);

        // Reset while waiting for the response, then a stale response arrives.
        r_test();

`ifdef LSU_MISALIGN_TRAP_EN
        access(OP_LW,  32'h101, 32'h0,        32'h0,        0, 0, 0, 0, 1, 4'hF,    32'h0,        32'h0);
        access(OP_LH,  32'h103, 32'h0,        32'h0,        0, 0, 0, 0, 1, 4'b1100, 32'h0,        32'h0);
`else
        access(OP_LW,  32'h101, 32'h0,        32'hCAFEF00D, 0, 0, 0, 0, 0, 4'hF,    32'h0,        32'hCAFEF00D);
        access(OP_LH,  32'h103, 32'h0,        32'hBEEF0001, 0, 0, 0, 0, 0, 4'b1100, 32'h0,        32'hFFFFBEEF);
`endif
        access(OP_LBU, 32'h702, 32'h0,        32'h00AB0000, 0, 0, 0, 0, 0, 4'b0100, 32'h0,        32'h000000AB);

        repeat (3) @(posedge clock);
        #1;
        chk("done_queue_drained", 32'(done_q.size()), 32'd0);
        chk("req_queue_drained", 32'(req_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic r_test();
        req_t r;
        r.addr = 32'h500;
        r.we = 1'b0;
        r.be = 4'hF;
        r.wd = 32'h0;
        r.chk_wd = 1'b0;
        req_q.push_back(r);
        en_lsu_ip = 1'b1;
        lsu_operator_ip = OP_LW;
        addr_ip = 32'h500;
        @(posedge clock); #1;
        en_lsu_ip = 1'b0;
        dmem_gnt_ip = 1'b1;
        @(posedge clock); #1;
        dmem_gnt_ip = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk_reset_outputs("midreset");
        dmem_rvalid_ip = 1'b1;
        dmem_rdata_ip = 32'h11111111;
        @(posedge clock); #1;
        dmem_rvalid_ip = 1'b0;
        dmem_rdata_ip = 32'h0;
        for (int k = 0; k < 3; k++) begin
            chk("stale_no_done", 32'(done_op), 32'd0);
            chk("stale_no_valid", 32'(mem_data_valid_op), 32'd0);
            @(posedge clock); #1;
        end
        chk_reset_outputs("after_stale");
        last_data = 32'h0;
    endtask

endmodule
